// File: rtl/acia_pkg.sv
// rtl/acia_pkg.sv - shared ACIA definitions: FSM states, frame width, line levels
package acia_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } acia_state_e;

    localparam int DATA_BITS = 8;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/acia_baud.sv
// rtl/acia_baud.sv - symbol rate counter; sym_end pulses on the last clock of each symbol
module acia_baud #(
    parameter int SCW     = 16,
    parameter int sym_cnt = 40000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic sym_end
);

    localparam logic [SCW-1:0] LAST = SCW'(sym_cnt - 1);

    logic [SCW-1:0] cnt_q;
    logic [SCW-1:0] cnt_d;

    assign sym_end = !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + SCW'(1);
        if (clr || sym_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/acia_tx.sv
// rtl/acia_tx.sv - 8N1/8N2 UART transmitter with one-entry holding register (ACIA_TX_PARITY_EN adds even parity)
module acia_tx
    import acia_pkg::*;
#(
    parameter int SCW       = 16,
    parameter int sym_cnt   = 40000,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_dat,
    input  logic       tx_start,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    acia_state_e state_q, state_d;
    logic [7:0]  hold_dat_q, hold_dat_d;
    logic        hold_vld_q, hold_vld_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_serial_q, tx_serial_d;
    logic        tx_done_q, tx_done_d;
`ifdef ACIA_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif
    logic        sym_end;
    logic        baud_clr;
    logic        load;

    // Counter held at zero while idle so the first symbol is a full sym_cnt long.
    assign baud_clr = (state_q == IDLE);

    acia_baud #(
        .SCW     (SCW),
        .sym_cnt (sym_cnt)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (baud_clr),
        .sym_end (sym_end)
    );

    always_comb begin
        state_d     = state_q;
        hold_dat_d  = hold_dat_q;
        hold_vld_d  = hold_vld_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        tx_serial_d = tx_serial_q;
        tx_done_d   = 1'b0;
`ifdef ACIA_TX_PARITY_EN
        parity_d    = parity_q;
`endif
        load        = 1'b0;

        if (tx_start && !hold_vld_q) begin
            hold_dat_d = tx_dat;
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_serial_d = LINE_IDLE;
                if (hold_vld_q) begin
                    load = 1'b1;
                end
            end
            START: begin
                if (sym_end) begin
                    state_d     = DATA;
                    bit_cnt_d   = '0;
                    tx_serial_d = shift_q[0];
                end
            end
            DATA: begin
                if (sym_end) begin
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        bit_cnt_d   = '0;
`ifdef ACIA_TX_PARITY_EN
                        state_d     = PARITY;
                        tx_serial_d = parity_q;
`else
                        state_d     = STOP;
                        tx_serial_d = LINE_STOP;
`endif
                    end else begin
                        shift_d     = shift_q >> 1;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        tx_serial_d = shift_q[1];
                    end
                end
            end
`ifdef ACIA_TX_PARITY_EN
            PARITY: begin
                if (sym_end) begin
                    state_d     = STOP;
                    bit_cnt_d   = '0;
                    tx_serial_d = LINE_STOP;
                end
            end
`endif
            STOP: begin
                if (sym_end) begin
                    if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                        tx_done_d = 1'b1;
                        if (hold_vld_q) begin
                            load = 1'b1;
                        end else begin
                            state_d     = IDLE;
                            tx_serial_d = LINE_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                tx_serial_d = LINE_IDLE;
            end
        endcase

        // Holding-to-shifter transfer; shared by the idle start and the back-to-back restart.
        if (load) begin
            shift_d     = hold_dat_q;
            hold_vld_d  = 1'b0;
            state_d     = START;
            bit_cnt_d   = '0;
            tx_serial_d = LINE_START;
`ifdef ACIA_TX_PARITY_EN
            parity_d    = ^hold_dat_q;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hold_dat_q  <= '0;
            hold_vld_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            tx_serial_q <= LINE_IDLE;
            tx_done_q   <= 1'b0;
`ifdef ACIA_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_dat_q  <= hold_dat_d;
            hold_vld_q  <= hold_vld_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_serial_q <= tx_serial_d;
            tx_done_q   <= tx_done_d;
`ifdef ACIA_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign tx_serial = tx_serial_q;
    assign tx_busy   = hold_vld_q;
    assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_acia_tx.sv
// tb/tb_acia_tx.sv - scoreboard bench for acia_tx with sym_cnt=4 (ACIA_TX_PARITY_EN adds the parity symbol)
module tb_acia_tx;

    localparam int SC = 4;
`ifdef ACIA_TX_PARITY_EN
    localparam int NSYM = 11;
    localparam bit PAR  = 1'b1;
`else
    localparam int NSYM = 10;
    localparam bit PAR  = 1'b0;
`endif
    localparam int NCYC = NSYM * SC;

    logic       clk;
    logic       rst;
    logic [7:0] tx_dat;
    logic       tx_start;
    logic       tx_serial;
    logic       tx_busy;
    logic       tx_done;

    int n_tests;
    int n_fail;
    logic [7:0] exp_q[$];

    acia_tx #(
        .SCW       (8),
        .sym_cnt   (SC),
        .STOP_BITS (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_dat    (tx_dat),
        .tx_start  (tx_start),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [7:0] d, input bit accepted);
        tx_dat   = d;
        tx_start = 1'b1;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        repeat (8) @(negedge clk);
    endtask

    // Line monitor: decodes each frame sample-by-sample against the scoreboard head.
    logic [63:0] obs;
    logic [63:0] expv;
    logic [7:0]  b;
    logic        bitv;
    int          dcnt;
    bit          have;
    bit          aborted;

    initial begin : monitor
        have = 1'b0;
        forever begin
            if (!have) begin
                do @(negedge clk); while (!(rst && tx_serial == 1'b0));
            end
            have    = 1'b0;
            aborted = 1'b0;
            obs     = '0;
            dcnt    = 0;
            for (int c = 0; c < NCYC; c++) begin
                if (c > 0) @(negedge clk);
                if (!rst) begin
                    aborted = 1'b1;
                    break;
                end
                obs[c] = tx_serial;
                if (c > 0 && tx_done) dcnt++;
            end
            if (!aborted) begin
                check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    b    = exp_q.pop_front();
                    expv = '0;
                    for (int s = 0; s < NSYM; s++) begin
                        if (s == 0)                bitv = 1'b0;
                        else if (s <= 8)           bitv = b[s-1];
                        else if (PAR && s == 9)    bitv = ^b;
                        else                       bitv = 1'b1;
                        for (int k = 0; k < SC; k++) expv[s*SC+k] = bitv;
                    end
                    check("frame", obs, expv);
                    check("done_mid", 64'(dcnt), 64'd0);
                    @(negedge clk);
                    check("done_pulse", 64'(tx_done), 64'd1);
                    if (exp_q.size() != 0) begin
                        check("b2b_start", 64'(tx_serial), 64'd0);
                        have = (tx_serial == 1'b0);
                    end else begin
                        check("idle_after", 64'(tx_serial), 64'd1);
                    end
                end
            end
        end
    end

    int errs;

    initial begin : main
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b0;
        tx_start = 1'b0;
        tx_dat   = '0;

        repeat (3) @(negedge clk);
        check("rst_serial", 64'(tx_serial), 64'd1);
        check("rst_busy",   64'(tx_busy),   64'd0);
        check("rst_done",   64'(tx_done),   64'd0);
        rst = 1'b1;
        errs = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) errs++;
        end
        check("idle100", 64'(errs), 64'd0);

        // Single frame (0x07 exercises parity=1 when the option is built)
        send(PAR ? 8'h07 : 8'h55, 1'b1);
        check("acc_busy", 64'(tx_busy),   64'd1);
        check("acc_line", 64'(tx_serial), 64'd1);
        @(negedge clk);
        check("start_line", 64'(tx_serial), 64'd0);
        check("xfer_busy",  64'(tx_busy),   64'd0);
        drain(200);

        send(8'h55, 1'b1);
        drain(200);

        // Back-to-back frames
        send(8'hA5, 1'b1);
        repeat (12) @(negedge clk);
        send(8'h3C, 1'b1);
        check("queued_busy", 64'(tx_busy), 64'd1);
        repeat (10) @(negedge clk);
        check("still_busy", 64'(tx_busy), 64'd1);
        drain(300);

        // Request while busy is dropped
        send(8'h11, 1'b1);
        repeat (12) @(negedge clk);
        send(8'h22, 1'b1);
        repeat (2) @(negedge clk);
        check("drop_busy", 64'(tx_busy), 64'd1);
        send(8'h33, 1'b0);
        drain(300);
        repeat (NCYC + 20) @(negedge clk);
        check("no_extra", 64'(exp_q.size()), 64'd0);

        // Reset in the middle of a frame
        send(8'hF0, 1'b1);
        send(8'h99, 1'b1);
        repeat (17) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_serial", 64'(tx_serial), 64'd1);
        check("async_busy",   64'(tx_busy),   64'd0);
        check("async_done",   64'(tx_done),   64'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (SC * 12) @(negedge clk);
        check("post_rst_idle", 64'(tx_serial), 64'd1);
        send(8'h0F, 1'b1);
        drain(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acia_tx.md
Name: acia_tx

Overview:
UART (ACIA) transmitter: serialises 8-bit bytes as 8N1 frames at sym_rate, the counterpart of acia_rx on the same host link (fpga_tx side).
- Sits between on-chip producers (hex dump, command responders) and the serial output pin.
- One-entry holding register plus shift register, so a second byte can queue during a frame and frames run back-to-back.

Parameters:
SCW, 16, rate counter width; must satisfy 2^SCW > sym_cnt.
sym_cnt, 40000, clocks per symbol (clk_freq / sym_rate; 48 MHz / 1200 = 40000); legal range >= 2.
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock (48 MHz).
rst  input  1  asynchronous, active-low reset.
tx_dat  input  8  byte to send; sampled on the edge where tx_start is accepted.
tx_start  input  1  one-cycle request to queue tx_dat.
tx_serial  output  1  serial line; idles high; registered output.
tx_busy  output  1  high while the holding register is full; requests are not accepted.
tx_done  output  1  one-cycle pulse at the end of each frame's last stop bit.

Behaviour:
- Reset (rst low, asynchronous): tx_serial=1, tx_busy=0, tx_done=0, state=IDLE, hold_vld=0, rate counter=0, bit counter=0.
- Accept rule: tx_start=1 on an edge where tx_busy=0 -> hold_dat<=tx_dat, hold_vld<=1. tx_busy is hold_vld (registered).
- tx_start while tx_busy=1: the request is dropped. The holding register is never overwritten.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the option).
  - IDLE with hold_vld=1: at the next edge, shifter<=hold_dat, hold_vld<=0, tx_serial<=0, go to START.
  - Latency: start bit is driven from the second edge after the accepting edge.
  - START: hold 0 for sym_cnt clocks, then go to DATA.
  - DATA: drive shifter[0] (LSB first), sym_cnt clocks per bit, 8 bits. Bit counter 0..7; shift right at each symbol end. Go to STOP after bit 7.
  - STOP: drive 1 for STOP_BITS*sym_cnt clocks.
- End of last stop clock:
  - tx_done=1 for one cycle.
  - If hold_vld=1: load the shifter and drive the start bit on that same edge. No idle clock between frames.
  - Otherwise go to IDLE with tx_serial=1.
- Rate counter: counts 0..sym_cnt-1, wraps to 0 at each symbol end, and is cleared on leaving IDLE. Every symbol is exactly sym_cnt clocks.
- A tx_start arriving in the same cycle as the holding-to-shifter transfer is evaluated against the registered tx_busy (still 1), so it is dropped.
- Frame length: (10 + STOP_BITS - 1)*sym_cnt clocks, from first start-bit clock to the tx_done pulse inclusive.
- Reset mid-frame: line returns high immediately and the queued byte is discarded. After rst rises, the first accepted byte starts a clean frame.

Optional Feature:
ACIA_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for sym_cnt clocks, and the frame grows by one symbol.
- Undefined: plain 8N1/8N2 frame; no parity logic is compiled.

Decomposition:
- Shared package acia_pkg:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8.
  - Idle/start/stop line levels.
  - Reused by acia_rx.
- Sub-module acia_baud (parameters SCW, sym_cnt):
  - Rate counter with clear input and a one-cycle sym_end output.
  - Shared with acia_rx.

Test Plan:
1. Hold rst low, then release; no requests -> tx_serial=1, tx_busy=0, tx_done=0 for 100 clocks.
2. sym_cnt=4, send 0x55 -> tx_serial is 0,1,0,1,0,1,0,1,0,1 with each level lasting 4 clocks; tx_done pulses once, 40 clocks after the start bit begins; then idle high.
3. sym_cnt=4, send 0xA5, then 0x3C during 0xA5's data bits -> tx_busy high until the transfer; second start bit immediately follows the first stop bit with no gap; two tx_done pulses 40 clocks apart.
4. Send 0x11; queue 0x22 while the first frame is shifting; request 0x33 while tx_busy=1 -> only 0x11 and 0x22 appear on the line; 0x33 is never sent.
5. Assert rst at bit 3 of 0xF0 -> tx_serial=1 asynchronously, tx_busy=0; after release, 0x0F transmits as a correct frame.
6. With ACIA_TX_PARITY_EN and sym_cnt=4, send 0x07 -> parity symbol is 1; frame is 11 symbols; tx_done 44 clocks after the start bit begins.
